// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : Bundle of the per-channel client request signals and the
//               registered SRAM-side outputs of sram_arbiter.
//               slave  modport : arbiter side (takes requests, drives SRAM)
//               master modport : client/environment side
//   req, lock, rd_en_in, wr_en_in : NUM_CH-bit per-channel controls
//   addr_in, wdata_in             : packed per-channel address / write data
//   grant                         : one-hot owner, zero when idle
//   read_enable, write_enable     : SRAM enables
//   address, write_data           : SRAM address / write data
//   rw_conflict                   : one-cycle pulse, owner asked rd and wr
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 1536
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        lock;
    logic [NUM_CH-1:0]        rd_en_in;
    logic [NUM_CH-1:0]        wr_en_in;
    logic [NUM_CH*ADDR_W-1:0] addr_in;
    logic [NUM_CH*DATA_W-1:0] wdata_in;
    logic [NUM_CH-1:0]        grant;
    logic                     read_enable;
    logic                     write_enable;
    logic [ADDR_W-1:0]        address;
    logic [DATA_W-1:0]        write_data;
    logic                     rw_conflict;

    modport slave (
        input  req, lock, rd_en_in, wr_en_in, addr_in, wdata_in,
        output grant, read_enable, write_enable, address, write_data, rw_conflict
    );

    modport master (
        output req, lock, rd_en_in, wr_en_in, addr_in, wdata_in,
        input  grant, read_enable, write_enable, address, write_data, rw_conflict
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Round-robin arbiter granting one of NUM_CH clients access to
//               a single SRAM port. An owner may hold the port with lock for
//               at most MAX_HOLD consecutive cycles while others wait.
//               All outputs are registered: one cycle from client inputs to
//               SRAM-side outputs.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sram_arbiter_if.slave (client requests in, SRAM signals out)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 1536,
    parameter int MAX_HOLD = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sram_arbiter_if.slave  bus
);
    localparam int c_OW_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_MAX_HOLD = c_HOLD_W'(MAX_HOLD);
    localparam logic [c_OW_W-1:0]   c_LAST_CH  = c_OW_W'(NUM_CH - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_OWN  = 1'b1;

    // Round-robin successor of a channel index.
    function automatic logic [c_OW_W-1:0] f_succ(input logic [c_OW_W-1:0] k);
        return (k == c_LAST_CH) ? '0 : k + c_OW_W'(1);
    endfunction

    // First set bit of mask found searching upward from start with wrap.
    function automatic logic [c_OW_W-1:0] f_pick(input logic [NUM_CH-1:0] mask,
                                                 input logic [c_OW_W-1:0] start);
        logic [c_OW_W-1:0] res;
        logic              found;
        int                idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && mask[idx]) begin
                res   = c_OW_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    logic [0:0]          r_state;
    // Current owner while in OWN; in IDLE it retains the last owner, which is
    // exactly the round-robin pointer needed for the next arbitration.
    logic [c_OW_W-1:0]   r_owner;
    logic [c_HOLD_W-1:0] r_hold;
    logic [NUM_CH-1:0]   r_grant;
    logic                r_read_enable;
    logic                r_write_enable;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_write_data;
    logic                r_rw_conflict;

    logic [0:0]          w_state_nxt;
    logic [c_OW_W-1:0]   w_owner_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [NUM_CH-1:0]   w_others;
    logic                w_keep;
    logic [NUM_CH-1:0]   w_grant_nxt;
    logic                w_rd_nxt;
    logic                w_wr_nxt;
    logic                w_conf_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_owner        <= c_LAST_CH;
            r_hold         <= '0;
            r_grant        <= '0;
            r_read_enable  <= 1'b0;
            r_write_enable <= 1'b0;
            r_address      <= '0;
            r_write_data   <= '0;
            r_rw_conflict  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_owner        <= w_owner_nxt;
            r_hold         <= w_hold_nxt;
            r_grant        <= w_grant_nxt;
            r_read_enable  <= w_rd_nxt;
            r_write_enable <= w_wr_nxt;
            r_address      <= w_addr_nxt;
            r_write_data   <= w_wdata_nxt;
            r_rw_conflict  <= w_conf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_others    = bus.req & ~(NUM_CH'(1) << r_owner);
        // lock of a non-requesting owner is irrelevant: req[k] gates it.
        w_keep      = bus.req[r_owner] &&
                      ((w_others == '0) || (bus.lock[r_owner] && (r_hold < c_MAX_HOLD)));
        w_state_nxt = c_IDLE;
        w_owner_nxt = r_owner;
        w_hold_nxt  = '0;
        case (r_state)
            c_IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = c_OWN;
                    w_owner_nxt = f_pick(bus.req, f_succ(r_owner));
                    w_hold_nxt  = c_HOLD_W'(1);
                end
            end
            c_OWN: begin
                if (w_keep) begin
                    w_state_nxt = c_OWN;
                    w_hold_nxt  = (r_hold == c_MAX_HOLD) ? r_hold : r_hold + c_HOLD_W'(1);
                end else if (|w_others) begin
                    // Direct hand-over, no idle bubble.
                    w_state_nxt = c_OWN;
                    w_owner_nxt = f_pick(w_others, f_succ(r_owner));
                    w_hold_nxt  = c_HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values loaded into the SRAM-side registers
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_nxt = '0;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_conf_nxt  = 1'b0;
        w_addr_nxt  = r_address;
        w_wdata_nxt = r_write_data;
        if (w_state_nxt == c_OWN) begin
            w_grant_nxt = NUM_CH'(1) << w_owner_nxt;
            w_wr_nxt    = bus.wr_en_in[w_owner_nxt];
            // Write wins when both enables are raised.
            w_rd_nxt    = bus.rd_en_in[w_owner_nxt] & ~bus.wr_en_in[w_owner_nxt];
            w_conf_nxt  = bus.rd_en_in[w_owner_nxt] & bus.wr_en_in[w_owner_nxt];
            w_addr_nxt  = bus.addr_in[w_owner_nxt*ADDR_W +: ADDR_W];
            w_wdata_nxt = bus.wdata_in[w_owner_nxt*DATA_W +: DATA_W];
        end
    end

    assign bus.grant        = r_grant;
    assign bus.read_enable  = r_read_enable;
    assign bus.write_enable = r_write_enable;
    assign bus.address      = r_address;
    assign bus.write_data   = r_write_data;
    assign bus.rw_conflict  = r_rw_conflict;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter (NUM_CH=4, MAX_HOLD=4).
//               Directed steps push hand-computed expectations into a queue;
//               a monitor pops one entry after every clock edge and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
    localparam int c_NCH = 4;
    localparam int c_AW  = 19;
    localparam int c_DW  = 1536;

    typedef struct {
        int               step;
        logic [3:0]       g;
        logic             rd;
        logic             wr;
        logic             cf;
        logic [c_AW-1:0]  a;
        logic [c_DW-1:0]  d;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q[$];
    int   checks;
    int   errors;
    int   step_no;
    logic [c_AW-1:0] exp_addr;
    logic [c_DW-1:0] exp_wd;

    sram_arbiter_if #(.NUM_CH(c_NCH), .ADDR_W(c_AW), .DATA_W(c_DW)) bus ();

    sram_arbiter #(
        .NUM_CH  (c_NCH),
        .ADDR_W  (c_AW),
        .DATA_W  (c_DW),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_AW-1:0] addr_of(input int ch);
        return c_AW'(32'h1_2340 + ch * 32'h1111);
    endfunction

    function automatic logic [c_DW-1:0] wd_of(input int ch);
        logic [31:0] w;
        w = 32'hA5A5_0000 | 32'(ch);
        return {48{w}};
    endfunction

    task automatic cmp(input string nm, input int st, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, st, got, exp);
        end
    endtask

    // ech >= 0: address/data of that channel; -1: hold previous; -2: zero
    task automatic push_exp(input logic [3:0] eg, input logic erd, input logic ewr,
                            input logic ecf, input int ech);
        exp_t e;
        if (ech >= 0) begin
            exp_addr = addr_of(ech);
            exp_wd   = wd_of(ech);
        end else if (ech == -2) begin
            exp_addr = '0;
            exp_wd   = '0;
        end
        step_no++;
        e.step = step_no;
        e.g  = eg;
        e.rd = erd;
        e.wr = ewr;
        e.cf = ecf;
        e.a  = exp_addr;
        e.d  = exp_wd;
        q.push_back(e);
    endtask

    task automatic step(input logic [3:0] rq, input logic [3:0] lk, input logic [3:0] rd,
                        input logic [3:0] wr, input logic [3:0] eg, input logic erd,
                        input logic ewr, input logic ecf, input int ech);
        @(negedge clk);
        rst          = 1'b0;
        bus.req      = rq;
        bus.lock     = lk;
        bus.rd_en_in = rd;
        bus.wr_en_in = wr;
        push_exp(eg, erd, ewr, ecf, ech);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push_exp(4'b0000, 1'b0, 1'b0, 1'b0, -2);
    endtask

    // Monitor: one expectation per edge, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("grant",        e.step, 64'(bus.grant),        64'(e.g));
            cmp("read_enable",  e.step, 64'(bus.read_enable),  64'(e.rd));
            cmp("write_enable", e.step, 64'(bus.write_enable), 64'(e.wr));
            cmp("rw_conflict",  e.step, 64'(bus.rw_conflict),  64'(e.cf));
            cmp("address",      e.step, 64'(bus.address),      64'(e.a));
            checks++;
            if (bus.write_data !== e.d) begin
                errors++;
                $display("FAIL write_data step %0d: got low word %0h expected low word %0h",
                         e.step, bus.write_data[31:0], e.d[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        step_no  = 0;
        exp_addr = '0;
        exp_wd   = '0;
        rst          = 1'b1;
        bus.req      = '0;
        bus.lock     = '0;
        bus.rd_en_in = '0;
        bus.wr_en_in = '0;
        for (int i = 0; i < c_NCH; i++) begin
            bus.addr_in[i*c_AW +: c_AW]  = addr_of(i);
            bus.wdata_in[i*c_DW +: c_DW] = wd_of(i);
        end

        // Reset state, then first grant goes round-robin from channel 0.
        do_reset();
        step(4'b1010, 4'b0000, 4'b0010, 4'b1000, 4'b0010, 1, 0, 0, 1);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1);

        // All channels requesting, no lock: rotation without idle cycles.
        do_reset();
        step(4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b0001, 0, 1, 0, 0);
        step(4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b0010, 1, 0, 0, 1);
        step(4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b0100, 0, 1, 0, 2);
        step(4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b1000, 1, 0, 0, 3);
        step(4'b1111, 4'b0000, 4'b1010, 4'b0101, 4'b0001, 0, 1, 0, 0);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1);

        // Locked owner 2 with channel 0 waiting: 4 cycles max, then forced release.
        step(4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100, 1, 0, 0, 2);
        step(4'b0101, 4'b0100, 4'b0100, 4'b0001, 4'b0100, 1, 0, 0, 2);
        step(4'b0101, 4'b0100, 4'b0100, 4'b0001, 4'b0100, 1, 0, 0, 2);
        step(4'b0101, 4'b0100, 4'b0100, 4'b0001, 4'b0100, 1, 0, 0, 2);
        step(4'b0101, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 0, 1, 0, 0);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1);

        // Sole requester 3 keeps the port past MAX_HOLD; stray lock bits ignored.
        for (int i = 0; i < 6; i++)
            step(4'b1000, 4'b0110, 4'b1000, 4'b0000, 4'b1000, 1, 0, 0, 3);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1);

        // Read+write conflict on owner 1 for one cycle; channel 0's is ignored.
        step(4'b0010, 4'b0000, 4'b0011, 4'b0011, 4'b0010, 0, 1, 1, 1);
        step(4'b0010, 4'b0000, 4'b0011, 4'b0001, 4'b0010, 1, 0, 0, 1);

        // Reset during a locked burst, then normal arbitration.
        step(4'b0101, 4'b0101, 4'b0000, 4'b0101, 4'b0100, 0, 1, 0, 2);
        step(4'b0101, 4'b0101, 4'b0000, 4'b0101, 4'b0100, 0, 1, 0, 2);
        do_reset();
        step(4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 1, 0, 0, 2);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, -1);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
